// File: rtl/core_lsu_if.sv
// Load/store unit data-bus bundle: word-aligned req/ack bus driven by the LSU (master)
// and answered by memory or interconnect (slave).
interface core_lsu_if #(
  parameter int XLEN = 32
) ();
  localparam int NB = XLEN / 8;

  logic            o_bus_req;
  logic            o_bus_we;
  logic [XLEN-1:0] o_bus_addr;
  logic [XLEN-1:0] o_bus_wdata;
  logic [NB-1:0]   o_bus_sel;
  logic            i_bus_ack;
  logic [XLEN-1:0] i_bus_rdata;

  modport master (
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_sel,
    input  i_bus_ack, i_bus_rdata
  );

  modport slave (
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_sel,
    output i_bus_ack, i_bus_rdata
  );
endinterface

// File: rtl/core_lsu.sv
// Load/store unit: one request at a time, word-crossing accesses split into two bus beats,
// load data reassembled and sign/zero-extended before being returned.
module core_lsu #(
  parameter int XLEN           = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_req,
  output logic            o_ready,
  input  logic            i_we,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_done,
  output logic            o_fault,
  output logic [XLEN-1:0] o_rdata,
  core_lsu_if.master      bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;
  state_e state_q;

  logic              we_q;
  logic              cross_q;
  logic [2:0]        f3_q;
  logic [OW-1:0]     ofs_q;
  logic [NB-1:0]     sel_hi_q;
  logic [XLEN-1:0]   wdata_hi_q;
  logic [XLEN-1:0]   d0_q;

  logic              accept;
  logic              new_cross;
  logic              new_illegal;
  logic [OW-1:0]     new_ofs;
  logic [3:0]        new_sz;
  logic [2*NB-1:0]   sel_full;
  logic [2*XLEN-1:0] wdata_full;
  logic [XLEN-1:0]   rd_raw;
  logic [XLEN-1:0]   load_val;

  // Keep the low 8<<size bits and fill the rest with the sign bit (signed) or zero.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
    int              nbits;
    logic            fill;
    logic [XLEN-1:0] r;
    nbits = 8 << f3[1:0];
    case (f3[1:0])
      2'b00:   fill = raw[7];
      2'b01:   fill = raw[15];
      2'b10:   fill = raw[31];
      default: fill = raw[XLEN-1];
    endcase
    fill = fill & ~f3[2];
    for (int i = 0; i < XLEN; i++) r[i] = (i < nbits) ? raw[i] : fill;
    return r;
  endfunction

  // Lane placement is computed once on a double-width bus: the low half feeds beat 0,
  // the high half is exactly what spills into beat 1.
  always_comb begin
    accept      = i_req & o_ready;
    new_ofs     = i_addr[OW-1:0];
    new_sz      = 4'd1 << i_funct3[1:0];
    new_cross   = (5'(new_ofs) + 5'(new_sz)) > 5'(NB);
    new_illegal = ((i_funct3[1:0] == 2'b11) && (XLEN == 32)) ||
                  (i_funct3[2] && i_we) ||
                  (new_cross && !MISALIGN_SPLIT);
    sel_full    = (((2*NB)'(1) << new_sz) - (2*NB)'(1)) << new_ofs;
    wdata_full  = {{XLEN{1'b0}}, i_wdata} << {new_ofs, 3'b000};
    rd_raw      = XLEN'({(state_q == BEAT1) ? bus.i_bus_rdata : {XLEN{1'b0}},
                         (state_q == BEAT1) ? d0_q : bus.i_bus_rdata} >> {ofs_q, 3'b000});
    load_val    = extend(rd_raw, f3_q);
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      we_q       <= i_we;
      f3_q       <= i_funct3;
      ofs_q      <= new_ofs;
      cross_q    <= new_cross;
      sel_hi_q   <= sel_full[2*NB-1:NB];
      wdata_hi_q <= wdata_full[2*XLEN-1:XLEN];
    end
    if ((state_q == BEAT0) && bus.i_bus_ack) d0_q <= bus.i_bus_rdata;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q         <= IDLE;
      o_ready         <= 1'b1;
      o_done          <= 1'b0;
      o_fault         <= 1'b0;
      o_rdata         <= '0;
      bus.o_bus_req   <= 1'b0;
      bus.o_bus_we    <= 1'b0;
      bus.o_bus_addr  <= '0;
      bus.o_bus_wdata <= '0;
      bus.o_bus_sel   <= '0;
    end else begin
      o_done <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          o_ready <= 1'b0;
          if (new_illegal) begin
            state_q <= RESP;
            o_done  <= 1'b1;
            o_fault <= 1'b1;
            o_rdata <= '0;
          end else begin
            state_q         <= BEAT0;
            o_fault         <= 1'b0;
            bus.o_bus_req   <= 1'b1;
            bus.o_bus_we    <= i_we;
            bus.o_bus_addr  <= {i_addr[XLEN-1:OW], {OW{1'b0}}};
            bus.o_bus_wdata <= wdata_full[XLEN-1:0];
            bus.o_bus_sel   <= sel_full[NB-1:0];
          end
        end
        BEAT0: if (bus.i_bus_ack) begin
          if (cross_q) begin
            state_q         <= BEAT1;
            bus.o_bus_addr  <= bus.o_bus_addr + XLEN'(NB);
            bus.o_bus_wdata <= wdata_hi_q;
            bus.o_bus_sel   <= sel_hi_q;
          end else begin
            state_q       <= RESP;
            bus.o_bus_req <= 1'b0;
            o_done        <= 1'b1;
            o_rdata       <= we_q ? '0 : load_val;
          end
        end
        BEAT1: if (bus.i_bus_ack) begin
          state_q       <= RESP;
          bus.o_bus_req <= 1'b0;
          o_done        <= 1'b1;
          o_rdata       <= we_q ? '0 : load_val;
        end
        RESP: begin
          state_q <= IDLE;
          o_ready <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_lsu.sv
// Bench for core_lsu: directed vector table, split/reset corner sequences, a fault-only
// instance, and randomized traffic against a byte-memory reference model.
`timescale 1ns/1ps
module tb_core_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0, req1, we;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        ready0, done0, fault0, ready1, done1, fault1;
  logic [31:0] rdata0, rdata1;

  int n_chk  = 0;
  int n_fail = 0;

  core_lsu_if #(.XLEN(32)) b0 ();
  core_lsu_if #(.XLEN(32)) b1 ();

  core_lsu #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req0), .o_ready(ready0), .i_we(we),
    .i_funct3(f3), .i_addr(addr), .i_wdata(wdata), .o_done(done0), .o_fault(fault0),
    .o_rdata(rdata0), .bus(b0.master));

  core_lsu #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req1), .o_ready(ready1), .i_we(we),
    .i_funct3(f3), .i_addr(addr), .i_wdata(wdata), .o_done(done1), .o_fault(fault1),
    .o_rdata(rdata1), .bus(b1.master));

  assign b1.i_bus_ack   = b1.o_bus_req;
  assign b1.i_bus_rdata = 32'hCAFEF00D;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Byte memories: bmem is what the bus slave holds, rmem is the reference model.
  logic [7:0] bmem [logic [31:0]];
  logic [7:0] rmem [logic [31:0]];

  function automatic logic [7:0] def_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction
  function automatic logic [7:0] bget(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return def_byte(a);
  endfunction
  function automatic logic [7:0] rget(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return def_byte(a);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] w;
    int          waits;
  } beat_t;
  beat_t       blog[$];
  logic [31:0] fq[$];
  int          wait_cfg = 0;

  // Bus slave for dut0: programmable wait states, logs each completed beat.
  initial begin : responder
    int          wc;
    bit          in_beat;
    beat_t       cur;
    logic [31:0] word;
    b0.i_bus_ack   = 1'b0;
    b0.i_bus_rdata = '0;
    in_beat = 0;
    wc = 0;
    forever begin
      @(posedge clk); #1;
      b0.i_bus_ack = 1'b0;
      if (!b0.o_bus_req) in_beat = 0;
      else begin
        if (!in_beat) begin
          in_beat   = 1;
          cur.we    = b0.o_bus_we;
          cur.a     = b0.o_bus_addr;
          cur.s     = b0.o_bus_sel;
          cur.w     = b0.o_bus_wdata;
          cur.waits = (wait_cfg < 0) ? int'($urandom_range(0, 2)) : wait_cfg;
          wc        = cur.waits;
        end else begin
          chk("bus_stable", {b0.o_bus_we, b0.o_bus_addr, b0.o_bus_sel, b0.o_bus_wdata},
              {cur.we, cur.a, cur.s, cur.w});
        end
        if (wc == 0) begin
          if (fq.size() > 0) word = fq.pop_front();
          else word = {bget(cur.a + 32'd3), bget(cur.a + 32'd2), bget(cur.a + 32'd1), bget(cur.a)};
          b0.i_bus_rdata = word;
          b0.i_bus_ack   = 1'b1;
          if (cur.we)
            for (int i = 0; i < 4; i++)
              if (cur.s[i]) bmem[cur.a + 32'(i)] = cur.w[8*i +: 8];
          blog.push_back(cur);
          in_beat = 0;
        end else wc--;
      end
    end
  end

  task automatic txn0(input logic w, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic flt,
                      output logic [31:0] rd);
    int k;
    k = 0;
    while (!ready0 && k < 50) begin @(posedge clk); #1; k++; end
    chk("ready_before_req", ready0, 1'b1);
    blog.delete();
    we = w; f3 = f; addr = a; wdata = d; req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    lat = 1;
    while (!done0 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("done_seen", done0, 1'b1);
    flt = fault0;
    rd  = rdata0;
    @(posedge clk); #1;
    chk("done_one_cycle", done0, 1'b0);
    chk("ready_after_done", ready0, 1'b1);
  endtask

  task automatic txn1(input logic [2:0] f, input logic [31:0] a, output int lat,
                      output logic flt, output logic [31:0] rd, output logic saw,
                      output logic req_t1);
    we = 1'b0; f3 = f; addr = a; wdata = '0; saw = 1'b0;
    chk("ready1_before_req", ready1, 1'b1);
    req1 = 1'b1;
    @(posedge clk); #1;
    req1   = 1'b0;
    req_t1 = b1.o_bus_req;
    lat    = 1;
    while (!done1 && lat < 50) begin saw |= b1.o_bus_req; @(posedge clk); #1; lat++; end
    saw |= b1.o_bus_req;
    chk("done1_seen", done1, 1'b1);
    flt = fault1;
    rd  = rdata1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, d0, d1;
    int          waits;
    logic        fault;
    logic [31:0] rdata;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] w0, a1;
    logic [3:0]  s1;
    logic [31:0] w1;
  } vec_t;
  localparam int NV = 14;
  vec_t tbl [NV];

  initial begin : main
    int          lat, exp_lat, k, sz;
    logic        flt, saw, rq1, w, ill, crs;
    logic [2:0]  f;
    logic [31:0] rd, a, d, ev;

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0; f3 = '0; addr = '0; wdata = '0;

    //               we  f3     addr          wdata         d0            d1            wt flt rdata         bt a0            s0     w0            a1            s1     w1
    tbl[0]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,        32'h0,        0, 1'b0, 32'h0,        1, 32'h0000_1000, 4'h8, 32'hA500_0000, 32'h0,        4'h0, 32'h0};
    tbl[1]  = '{1'b0, 3'b001, 32'h0000_2001, 32'h0,         32'h1280_0134, 32'h0,       1, 1'b0, 32'hFFFF_8001, 1, 32'h0000_2000, 4'h6, 32'h0,        32'h0,        4'h0, 32'h0};
    tbl[2]  = '{1'b0, 3'b101, 32'h0000_2001, 32'h0,         32'h1280_0134, 32'h0,       0, 1'b0, 32'h0000_8001, 1, 32'h0000_2000, 4'h6, 32'h0,        32'h0,        4'h0, 32'h0};
    tbl[3]  = '{1'b1, 3'b010, 32'h0000_3002, 32'h1234_5678, 32'h0,        32'h0,        2, 1'b0, 32'h0,        2, 32'h0000_3000, 4'hC, 32'h5678_0000, 32'h0000_3004, 4'h3, 32'h0000_1234};
    tbl[4]  = '{1'b0, 3'b010, 32'h0000_4003, 32'h0,         32'hAABB_CCDD, 32'h1122_3344, 0, 1'b0, 32'h2233_44AA, 2, 32'h0000_4000, 4'h8, 32'h0,     32'h0000_4004, 4'h7, 32'h0};
    tbl[5]  = '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,         32'hBEEF_0000, 32'h0000_CAFE, 1, 1'b0, 32'hCAFE_BEEF, 2, 32'hFFFF_FFFC, 4'hC, 32'h0,     32'h0000_0000, 4'h3, 32'h0};
    tbl[6]  = '{1'b0, 3'b000, 32'h0000_5002, 32'h0,         32'h00F0_0000, 32'h0,       0, 1'b0, 32'hFFFF_FFF0, 1, 32'h0000_5000, 4'h4, 32'h0,        32'h0,        4'h0, 32'h0};
    tbl[7]  = '{1'b0, 3'b100, 32'h0000_5002, 32'h0,         32'h00F0_0000, 32'h0,       0, 1'b0, 32'h0000_00F0, 1, 32'h0000_5000, 4'h4, 32'h0,        32'h0,        4'h0, 32'h0};
    tbl[8]  = '{1'b0, 3'b011, 32'h0000_6000, 32'h0,         32'h0,        32'h0,        0, 1'b1, 32'h0,        0, 32'h0,         4'h0, 32'h0,        32'h0,        4'h0, 32'h0};
    tbl[9]  = '{1'b1, 3'b100, 32'h0000_6004, 32'h0000_0011, 32'h0,        32'h0,        0, 1'b1, 32'h0,        0, 32'h0,         4'h0, 32'h0,        32'h0,        4'h0, 32'h0};
    tbl[10] = '{1'b0, 3'b001, 32'h0000_2003, 32'h0,         32'h7F00_0000, 32'h0000_00FF, 0, 1'b0, 32'hFFFF_FF7F, 2, 32'h0000_2000, 4'h8, 32'h0,     32'h0000_2004, 4'h1, 32'h0};
    tbl[11] = '{1'b1, 3'b001, 32'h0000_6001, 32'hFFFF_BEEF, 32'h0,        32'h0,        2, 1'b0, 32'h0,        1, 32'h0000_6000, 4'h6, 32'hFFBE_EF00, 32'h0,        4'h0, 32'h0};
    tbl[12] = '{1'b0, 3'b010, 32'h0000_7000, 32'h0,         32'h8000_0000, 32'h0,       1, 1'b0, 32'h8000_0000, 1, 32'h0000_7000, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0};
    tbl[13] = '{1'b1, 3'b001, 32'h0000_8003, 32'h0000_ABCD, 32'h0,        32'h0,        1, 1'b0, 32'h0,        2, 32'h0000_8000, 4'h8, 32'hCD00_0000, 32'h0000_8004, 4'h1, 32'h0000_00AB};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {ready0, ready1}, 2'b11);
    chk("rst_done_fault", {done0, fault0, done1, fault1}, 4'b0000);
    chk("rst_rdata", {rdata0, rdata1}, 64'h0);
    chk("rst_bus", {b0.o_bus_req, b0.o_bus_we, b0.o_bus_addr, b0.o_bus_wdata, b0.o_bus_sel, b1.o_bus_req}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      wait_cfg = tbl[i].waits;
      fq.delete();
      fq.push_back(tbl[i].d0);
      fq.push_back(tbl[i].d1);
      txn0(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, lat, flt, rd);
      chk($sformatf("v%0d_fault", i), flt, tbl[i].fault);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].rdata);
      chk($sformatf("v%0d_beats", i), blog.size(), tbl[i].beats);
      if (blog.size() >= 1 && tbl[i].beats >= 1)
        chk($sformatf("v%0d_beat0", i), {blog[0].we, blog[0].a, blog[0].s, blog[0].w},
            {tbl[i].we, tbl[i].a0, tbl[i].s0, tbl[i].w0});
      if (blog.size() >= 2 && tbl[i].beats == 2)
        chk($sformatf("v%0d_beat1", i), {blog[1].we, blog[1].a, blog[1].s, blog[1].w},
            {tbl[i].we, tbl[i].a1, tbl[i].s1, tbl[i].w1});
      exp_lat = tbl[i].fault ? 1 : tbl[i].beats * (tbl[i].waits + 1) + 1;
      chk($sformatf("v%0d_latency", i), lat, exp_lat);
    end
    fq.delete();

    // MISALIGN_SPLIT=0 instance: crossing faults without touching the bus, others complete.
    txn1(3'b010, 32'h0000_4003, lat, flt, rd, saw, rq1);
    chk("ns_cross_fault", {flt, saw, rd}, {1'b1, 1'b0, 32'h0});
    chk("ns_cross_latency", lat, 1);
    txn1(3'b010, 32'h0000_4000, lat, flt, rd, saw, rq1);
    chk("ns_lw", {flt, rq1, rd}, {1'b0, 1'b1, 32'hCAFE_F00D});
    chk("ns_lw_latency", lat, 2);
    txn1(3'b001, 32'h0000_4001, lat, flt, rd, saw, rq1);
    chk("ns_lh_ofs1", {flt, rd}, {1'b0, 32'hFFFF_FEF0});
    txn1(3'b000, 32'h0000_4003, lat, flt, rd, saw, rq1);
    chk("ns_lb_ofs3", {flt, rd}, {1'b0, 32'hFFFF_FFCA});
    txn1(3'b001, 32'h0000_4003, lat, flt, rd, saw, rq1);
    chk("ns_lh_cross_fault", {flt, saw}, {1'b1, 1'b0});

    // Randomized traffic against the byte-memory model.
    wait_cfg = -1;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      if (f[1:0] == 2'b11 && $urandom_range(0, 3) != 0) f[1:0] = 2'b10;
      a   = 32'h100 + 32'($urandom_range(0, 63));
      d   = $urandom;
      sz  = 1 << f[1:0];
      ill = (f[1:0] == 2'b11) || (f[2] && w);
      crs = ((a % 4) + sz) > 4;
      ev  = '0;
      if (!ill && !w) begin
        for (int i = 0; i < sz; i++) ev = ev | (32'(rget(a + 32'(i))) << (8 * i));
        if (!f[2] && sz < 4 && ev[8*sz-1]) ev = ev | ~((32'd1 << (8 * sz)) - 32'd1);
      end
      txn0(w, f, a, d, lat, flt, rd);
      chk("rnd_fault", flt, ill);
      chk("rnd_rdata", rd, ev);
      chk("rnd_beats", blog.size(), ill ? 0 : (crs ? 2 : 1));
      if (!ill && w) begin
        for (int i = 0; i < sz; i++) rmem[a + 32'(i)] = d[8*i +: 8];
        for (int j = 0; j < 16; j++)
          chk("rnd_store_mem", bget(a - 32'd4 + 32'(j)), rget(a - 32'd4 + 32'(j)));
      end
    end

    // Reset while the second beat of a split store is waiting for ack.
    wait_cfg = 5;
    k = 0;
    while (!ready0 && k < 50) begin @(posedge clk); #1; k++; end
    blog.delete();
    we = 1'b1; f3 = 3'b010; addr = 32'h0000_3002; wdata = 32'h1234_5678; req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    k = 0;
    while (blog.size() == 0 && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    chk("rst_mid_beat1_pending", {b0.o_bus_req, b0.o_bus_addr, done0}, {1'b1, 32'h0000_3004, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus_req", b0.o_bus_req, 1'b0);
    chk("rst_mid_ready", ready0, 1'b1);
    chk("rst_mid_outputs", {done0, fault0, rdata0, b0.o_bus_addr, b0.o_bus_sel}, '0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_mid_no_done", done0, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_no_done", {done0, ready0}, 2'b01);
    wait_cfg = 0;
    txn0(1'b1, 3'b000, 32'h0000_1000, 32'h0000_005A, lat, flt, rd);
    chk("post_rst_sb", {flt, rd, lat}, {1'b0, 32'h0, 32'd2});
    chk("post_rst_beats", blog.size(), 1);
    if (blog.size() == 1)
      chk("post_rst_beat0", {blog[0].we, blog[0].a, blog[0].s, blog[0].w},
          {1'b1, 32'h0000_1000, 4'h1, 32'h0000_005A});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
Parametrised load/store unit that replaces the combinational store-shuffle/byte-select stage. It accepts one load or store request from the execute stage and drives a req/ack data bus. Accesses that cross a bus-word boundary are split into two bus beats. Load data is reassembled, extracted and sign- or zero-extended before it is returned to writeback.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64. NB = XLEN/8 bytes per bus word; OW = log2(NB).
MISALIGN_SPLIT, 1, 1 = split word-crossing accesses into two beats; 0 = fault them.

Ports:
i_clk  input  1  clock
i_reset_n  input  1  asynchronous active-low reset
i_req  input  1  request valid
o_ready  output  1  unit idle, able to accept a request
i_we  input  1  1 = store, 0 = load
i_funct3  input  3  RISC-V funct3: [1:0] log2 size, [2] unsigned load
i_addr  input  XLEN  byte address
i_wdata  input  XLEN  store data (rs2), right-aligned
o_done  output  1  one-cycle completion pulse
o_fault  output  1  valid with o_done: access rejected
o_rdata  output  XLEN  extended load result, valid with o_done
o_bus_req  output  1  bus request
o_bus_we  output  1  bus write
o_bus_addr  output  XLEN  bus-word-aligned address (low OW bits zero)
o_bus_wdata  output  XLEN  lane-positioned write data
o_bus_sel  output  NB  byte-lane enables
i_bus_ack  input  1  bus beat complete; i_bus_rdata valid in the same cycle
i_bus_rdata  input  XLEN  bus read data

Behaviour:
- Clock and reset: one clock, i_clk. i_reset_n is asynchronous and active-low.
- Reset values: all outputs 0 except o_ready = 1. FSM = IDLE.
- All outputs are registered.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- o_ready = 1 only in IDLE. A request is accepted when i_req && o_ready. The unit latches we, funct3, addr and wdata on acceptance.
- Address arithmetic: SZ = 1 << funct3[1:0] bytes; OFS = addr[OW-1:0]; cross = (OFS + SZ > NB).
- Illegal request, checked at acceptance. Any of the following is illegal:
  - funct3[1:0] = 2'b11 with XLEN = 32;
  - funct3[2] = 1 with we = 1;
  - cross with MISALIGN_SPLIT = 0.
- Illegal request handling: go to RESP with no bus activity; o_done = o_fault = 1 in the next cycle; o_rdata = 0.
- Legal request: go to BEAT0 with o_bus_req = 1 in the next cycle.
- BEAT0 outputs:
  - addr = {addr[XLEN-1:OW], OW'b0};
  - sel = (((1<<SZ)-1) << OFS) truncated to NB bits;
  - wdata = (wdata << 8*OFS) truncated to XLEN bits.
- BEAT0 exit, on i_bus_ack: capture i_bus_rdata as D0. If cross, go to BEAT1 with o_bus_req held at 1; otherwise go to RESP with o_bus_req = 0.
- BEAT1 outputs:
  - addr = BEAT0 addr + NB, wrapping modulo 2^XLEN;
  - sel = ((1<<SZ)-1) >> (NB-OFS);
  - wdata = wdata >> 8*(NB-OFS).
- BEAT1 exit, on i_bus_ack: capture D1, go to RESP, o_bus_req = 0.
- Bus handshake: while o_bus_req = 1, o_bus_we, o_bus_addr, o_bus_wdata and o_bus_sel are stable. Ack is allowed in the first request cycle (zero wait). i_bus_ack with o_bus_req = 0 is ignored.
- Load assembly: raw = (D0 >> 8*OFS) | (cross ? D1 << 8*(NB-OFS) : 0), truncated to XLEN bits. Keep the low 8*SZ bits; sign-extend when funct3[2] = 0, zero-extend when funct3[2] = 1.
- Stores return o_rdata = 0.
- Non-crossing misaligned access (e.g. LH at OFS = 1): single beat, legal.
- RESP: o_done = 1 for exactly one cycle, then IDLE.
- o_rdata and o_fault hold their values until the next acceptance.
- o_fault = 0 on legal completions.
- Latency:
  - accept at T → o_bus_req from T+1;
  - last ack at A → o_done at A+1;
  - minimum single-beat latency is accept-to-done = 2 cycles; split minimum is 3 cycles.
- Back-to-back: o_ready returns in the cycle after o_done, so the next accept is no earlier than o_done+1.
- Reset mid-operation: all outputs return to reset values immediately (async), including o_bus_req = 0. The pending access is dropped and no o_done is produced. The bus owner must tolerate an abandoned request.

Test Plan:
1. XLEN=32, SB addr 0x1003, wdata 0x000000A5, zero-wait ack → one beat: bus_addr 0x1000, sel 4'b1000, bus_wdata 0xA5000000. o_done 2 cycles after accept, o_fault 0.
2. LH addr 0x2001, rdata 0x12800134 → one beat, sel 4'b0110, o_rdata 0x00000080... Use rdata 0x12800134: half = 0x8001, o_rdata 0xFFFF8001. Repeat as LHU → 0x00008001.
3. SW addr 0x3002, wdata 0x12345678 → beat0: addr 0x3000, sel 4'b1100, wdata 0x56780000. beat1: addr 0x3004, sel 4'b0011, wdata 0x00001234. Ack after 2 wait cycles each; signals stable throughout; single o_done.
4. LW addr 0x4003, D0 0xAABBCCDD, D1 0x11223344 → o_rdata 0x223344AA. Also addr 0xFFFFFFFE LW → beat1 addr wraps to 0x00000000.
5. MISALIGN_SPLIT=0, LW 0x4003 → no o_bus_req, o_done and o_fault at T+1. XLEN=32 with funct3=3'b011 → fault. Store with funct3=3'b100 → fault.
6. Assert i_reset_n=0 during BEAT1 wait → o_bus_req=0 and o_ready=1 immediately, no o_done. After release, SB 0x1000 completes normally.
